candy_dispense_driver: RTL

Output-side actuator driver for the candy vending system. It takes dispense commands from the vending controller over a valid/ready handshake and drives one of four solenoid lines with timed pulses. Each pulse is followed by a mandatory recovery gap, repeated once per candy requested. It is the outbound counterpart of the key debouncer: the debouncer cleans 4-bit key inputs, and this block produces clean, timed 4-bit actuator outputs.

---
 rtl/candy_dispense_if.sv | 33 +++
 rtl/candy_dispense_driver.sv | 154 +++++++++++++++
 2 files changed

// File: rtl/candy_dispense_if.sv
// Request/status bundle between the vending controller and the candy
// dispense driver. The controller side is the master and the driver side
// is the slave.
// Defining CANDY_DISP_ABORT_EN adds the abort line to the bundle.
interface candy_dispense_if;
  logic       req_valid;
  logic [1:0] req_item;
  logic [2:0] req_count;
  logic       req_ready;
  logic [3:0] solenoid;
  logic       busy;
  logic [2:0] remaining;
  logic       done;
`ifdef CANDY_DISP_ABORT_EN
  logic       abort;
`endif

  modport master (
    output req_valid, req_item, req_count,
`ifdef CANDY_DISP_ABORT_EN
    output abort,
`endif
    input  req_ready, solenoid, busy, remaining, done
  );

  modport slave (
    input  req_valid, req_item, req_count,
`ifdef CANDY_DISP_ABORT_EN
    input  abort,
`endif
    output req_ready, solenoid, busy, remaining, done
  );
endinterface

// File: rtl/candy_dispense_driver.sv
// Candy dispense driver: accepts a dispense request {item, count} over a
// valid/ready handshake and fires one of four solenoids count times. Each
// firing is a PULSE_CYCLES-long high pulse followed by a GAP_CYCLES-long
// forced-low recovery gap. A one-cycle done strobe closes every request,
// including count=0 requests.
// Optional feature macro: CANDY_DISP_ABORT_EN adds an abort input that cuts
// the current pulse short and cancels all pulses not yet started.
module candy_dispense_driver #(
  parameter int unsigned PULSE_CYCLES = 50,
  parameter int unsigned GAP_CYCLES   = 25,
  parameter int unsigned TIMER_W      = 16
) (
  input logic             clk,
  input logic             reset,
  candy_dispense_if.slave bus
);

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_PULSE = 2'd1,
    S_GAP   = 2'd2,
    S_DONE  = 2'd3
  } state_t;

  // Timer reload values: the timer counts N-1 down to 0 and the state
  // moves on the edge where it reads 0, giving exactly N cycles per phase.
  localparam logic [TIMER_W-1:0] PULSE_LOAD = TIMER_W'(PULSE_CYCLES - 1);
  localparam logic [TIMER_W-1:0] GAP_LOAD   = TIMER_W'(GAP_CYCLES - 1);

  state_t             state;
  logic [TIMER_W-1:0] timer;
  logic [1:0]         item_q;
  logic [3:0]         solenoid_q;
  logic               busy_q;
  logic               done_q;
  logic [2:0]         remaining_q;
  logic               abort_s;

  // Solenoid drive for a given item: always exactly one bit, never more.
  function automatic logic [3:0] item_onehot(input logic [1:0] idx);
    logic [3:0] v;
    v = 4'b0001 << idx;
    return v;
  endfunction

`ifdef CANDY_DISP_ABORT_EN
  assign abort_s = bus.abort;
`else
  assign abort_s = 1'b0;
`endif

  // Ready is a pure decode of the registered state, masked while reset is
  // held so no request can be accepted on a reset edge.
  assign bus.req_ready = (state == S_IDLE) && !reset;
  assign bus.solenoid  = solenoid_q;
  assign bus.busy      = busy_q;
  assign bus.remaining = remaining_q;
  assign bus.done      = done_q;

  // Dispense sequencer: request capture, pulse/gap timing and registered outputs.
  always_ff @(posedge clk) begin
    if (reset) begin
      state       <= S_IDLE;
      timer       <= '0;
      solenoid_q  <= 4'b0000;
      busy_q      <= 1'b0;
      done_q      <= 1'b0;
      remaining_q <= 3'd0;
    end else begin
      case (state)
        S_IDLE: begin
          done_q <= 1'b0;
          if (bus.req_valid) begin
            // Item and count are captured here; later input changes are
            // irrelevant until the next accept.
            item_q <= bus.req_item;
            busy_q <= 1'b1;
            if (bus.req_count == 3'd0) begin
              state       <= S_DONE;
              done_q      <= 1'b1;
              remaining_q <= 3'd0;
            end else begin
              state       <= S_PULSE;
              solenoid_q  <= item_onehot(bus.req_item);
              remaining_q <= bus.req_count - 3'd1;
              timer       <= PULSE_LOAD;
            end
          end
        end

        S_PULSE: begin
          if (abort_s) begin
            // Abort wins even on the expiry edge: drop the coil now and
            // still give it a full recovery gap.
            solenoid_q  <= 4'b0000;
            remaining_q <= 3'd0;
            state       <= S_GAP;
            timer       <= GAP_LOAD;
          end else if (timer == '0) begin
            solenoid_q <= 4'b0000;
            state      <= S_GAP;
            timer      <= GAP_LOAD;
          end else begin
            timer <= timer - 1'b1;
          end
        end

        S_GAP: begin
          if (timer == '0) begin
            if ((remaining_q != 3'd0) && !abort_s) begin
              remaining_q <= remaining_q - 3'd1;
              solenoid_q  <= item_onehot(item_q);
              state       <= S_PULSE;
              timer       <= PULSE_LOAD;
            end else begin
              remaining_q <= 3'd0;
              state       <= S_DONE;
              done_q      <= 1'b1;
            end
          end else begin
            timer <= timer - 1'b1;
            if (abort_s) begin
              remaining_q <= 3'd0;
            end
          end
        end

        S_DONE: begin
          done_q <= 1'b0;
          busy_q <= 1'b0;
          state  <= S_IDLE;
        end

        default: begin
          state      <= S_IDLE;
          solenoid_q <= 4'b0000;
          busy_q     <= 1'b0;
          done_q     <= 1'b0;
        end
      endcase
    end
  end

  // Output sanity: the solenoid bus is never multi-hot and only drives in PULSE.
  always_ff @(posedge clk) begin
    if (!reset) begin
      assert ($onehot0(solenoid_q))
        else $error("solenoid multi-hot: %b", solenoid_q);
      assert ((state == S_PULSE) || (solenoid_q == 4'b0000))
        else $error("solenoid active outside pulse: %b", solenoid_q);
    end
  end

endmodule
